// File: rtl/rr_mux4_if.sv
// Request/data bundle and registered grant/output bundle of the round-robin 4:1 mux arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface rr_mux4_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               busy;
    logic [WIDTH-1:0]   y;
    logic               y_valid;

    modport master (
        output req, data,
        input  gnt, sel, busy, y, y_valid
    );

    modport slave (
        input  req, data,
        output gnt, sel, busy, y, y_valid
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing one output lane, with a hold limit
// on ownership and a registered forwarding stage for the owner's data word.
module rr_mux4_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_mux4_if.slave   bus
);
    localparam int unsigned N  = 4;
    localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [1:0]       owner_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [3:0]       others;
    logic [2:0]       pk;
    logic [WIDTH-1:0] word [N];

    // First requesting channel at or after start (mod 4); returns {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // State register plus the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // Next owner, priority pointer and hold counter; sel_q is the current owner while granting.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        owner_d = sel_q;
        others  = bus.req & ~(4'b0001 << sel_q);
        pk      = 3'b000;
        unique case (state_q)
            IDLE: begin
                pk = pick(bus.req, ptr_q);
                if (pk[2]) begin
                    state_d = GRANT;
                    owner_d = pk[1:0];
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    ptr_d  = sel_q + 2'd1;
                    pk     = pick(others, sel_q + 2'd1);
                    hold_d = '0;
                    if (pk[2]) owner_d = pk[1:0];
                    else       state_d = IDLE;
                end else if (hold_q == HOLD_LAST && others != 4'b0000) begin
                    ptr_d   = sel_q + 2'd1;
                    pk      = pick(others, sel_q + 2'd1);
                    owner_d = pk[1:0];
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    // Next values of the registered outputs; y follows the current select, one cycle behind gnt.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            word[i] = bus.data[(N-1-i)*WIDTH +: WIDTH];
        end
        busy_d    = (state_d == GRANT);
        gnt_d     = busy_d ? (4'b0001 << owner_d) : 4'b0000;
        sel_d     = busy_d ? owner_d : sel_q;
        y_d       = word[sel_q];
        y_valid_d = busy_q & bus.req[sel_q];
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: two arbiters (HOLD_MAX 4 and 1) driven by the same requests,
// compared every cycle against an ownership/run-length reference model.
module tb_rr_mux4_arbiter;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = 4'b0000;
    logic [WIDTH-1:0] words [4];
    logic [4*WIDTH-1:0] data;

    int n_checks = 0;
    int n_pass   = 0;

    rr_mux4_if #(.WIDTH(WIDTH)) bus0 ();
    rr_mux4_if #(.WIDTH(WIDTH)) bus1 ();

    assign data      = {words[0], words[1], words[2], words[3]};
    assign bus0.req  = req;
    assign bus0.data = data;
    assign bus1.req  = req;
    assign bus1.data = data;

    rr_mux4_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    rr_mux4_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Observed outputs gathered per instance.
    logic [3:0]       d_gnt  [2];
    logic [1:0]       d_sel  [2];
    logic             d_busy [2];
    logic [WIDTH-1:0] d_y    [2];
    logic             d_yv   [2];
    assign d_gnt[0] = bus0.gnt;  assign d_sel[0] = bus0.sel;  assign d_busy[0] = bus0.busy;
    assign d_y[0]   = bus0.y;    assign d_yv[0]  = bus0.y_valid;
    assign d_gnt[1] = bus1.gnt;  assign d_sel[1] = bus1.sel;  assign d_busy[1] = bus1.busy;
    assign d_y[1]   = bus1.y;    assign d_yv[1]  = bus1.y_valid;

    // Reference model: owner (-1 when idle), priority pointer, cycles owned so far.
    int               hm      [2] = '{4, 1};
    int               m_owner [2];
    int               m_ptr   [2];
    int               m_run   [2];
    int               m_sel   [2];
    logic [WIDTH-1:0] m_y     [2];
    logic             m_yv    [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_ptr[i] = 0; m_run[i] = 0;
            m_sel[i] = 0; m_y[i] = '0; m_yv[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input logic [3:0] r);
        logic [WIDTH-1:0] ny;
        logic             nyv;
        logic [3:0]       oth;
        int               g;
        ny  = words[m_sel[i]];
        nyv = (m_owner[i] >= 0) && r[m_sel[i]];
        if (m_owner[i] < 0) begin
            if (r != 4'b0000) begin
                m_owner[i] = first_from(r, m_ptr[i]);
                m_run[i]   = 1;
            end
        end else begin
            g   = m_owner[i];
            oth = r & ~4'(1 << g);
            if (!r[g] || (m_run[i] >= hm[i] && oth != 4'b0000)) begin
                m_ptr[i]   = (g + 1) % 4;
                m_owner[i] = first_from(oth, m_ptr[i]);
                m_run[i]   = 1;
            end else begin
                m_run[i]++;
            end
        end
        if (m_owner[i] >= 0) m_sel[i] = m_owner[i];
        m_y[i]  = ny;
        m_yv[i] = nyv;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("gnt%0d", i),  32'(d_gnt[i]),  (m_owner[i] >= 0) ? 32'(1 << m_owner[i]) : 32'd0);
            check($sformatf("sel%0d", i),  32'(d_sel[i]),  32'(m_sel[i]));
            check($sformatf("busy%0d", i), 32'(d_busy[i]), 32'(m_owner[i] >= 0));
            check($sformatf("y%0d", i),    32'(d_y[i]),    32'(m_y[i]));
            check($sformatf("yv%0d", i),   32'(d_yv[i]),   32'(m_yv[i]));
        end
    endtask

    // Apply req (inputs already settled), advance model, clock once, compare.
    task automatic step(input logic [3:0] r);
        req = r;
        for (int i = 0; i < 2; i++) model_edge(i, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [3:0] r);
        req   = r;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < 4; i++) words[i] = WIDTH'($urandom);
    endtask

    initial begin
        logic [3:0] r;
        for (int i = 0; i < 4; i++) words[i] = WIDTH'(8'h10 * (i + 1) + i);
        words[2] = 8'hA5;
        model_reset();

        // Reset with all requests, first grant from channel 0, then async reset mid-cycle.
        do_reset(4'b1111);
        step(4'b1111);
        check("t1_gnt", 32'(bus0.gnt), 32'h1);
        step(4'b1111);
        check("t1_y", 32'(bus0.y), 32'(words[0]));
        check("t1_yv", 32'(bus0.y_valid), 32'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("t1_async_busy", 32'(bus0.busy), 32'h0);

        // Lone requester 2 keeps the grant.
        do_reset(4'b0100);
        for (int c = 0; c < 10; c++) begin
            step(4'b0100);
            check("t2_gnt", 32'(bus0.gnt), 32'h4);
        end
        check("t2_y", 32'(bus0.y), 32'hA5);

        // All requesting: rotation with 4-cycle holds on dut0, every cycle on dut1.
        do_reset(4'b0000);
        for (int c = 0; c < 20; c++) step(4'b1111);

        // Owner 1 releases while 3 and 0 request: 3 wins with no dead cycle.
        do_reset(4'b0000);
        step(4'b0010);
        step(4'b1011);
        step(4'b1001);
        check("t4_gnt", 32'(bus0.gnt), 32'h8);

        // Sole owner 0 releases; next grant searches from channel 1.
        do_reset(4'b0000);
        step(4'b0001);
        step(4'b0000);
        check("t5_busy", 32'(bus0.busy), 32'h0);
        check("t5_sel", 32'(bus0.sel), 32'h0);
        step(4'b0000);
        check("t5_yv", 32'(bus0.y_valid), 32'h0);
        step(4'b0011);
        check("t5_gnt", 32'(bus0.gnt), 32'h2);

        // HOLD_MAX=1 alternation on dut1.
        do_reset(4'b0000);
        step(4'b0101);
        check("t6_gnt_a", 32'(bus1.gnt), 32'h1);
        step(4'b0101);
        check("t6_gnt_b", 32'(bus1.gnt), 32'h4);
        for (int c = 0; c < 6; c++) step(4'b0101);

        // Randomised traffic with sticky requests and occasional resets.
        do_reset(4'b0000);
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            rand_words();
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
